// File: rtl/accu_pkg.sv
// Shared types and helpers for the accumulator family (power-of-two and modulo-M).
// wrapdiff is a width/modulus-generic reference usable by checkers of either accumulator.
package accu_pkg;

  typedef enum logic {IDLE, RUN} accu_diff_state_t;

  localparam int unsigned WRAPDIFF_MAXW = 32;

  typedef struct packed {
    logic        wrap;
    logic [31:0] diff;
  } wrapdiff_t;

  // Difference a-b wrapped to 2^w (m==0) or to m (m>0); wrap flags a borrow correction.
  function automatic wrapdiff_t wrapdiff(input logic [31:0] a, input logic [31:0] b,
                                         input int unsigned w, input int unsigned m);
    logic [32:0] t;
    logic [32:0] mask;
    wrapdiff_t   r;
    mask   = (33'd1 << w) - 33'd1;
    t      = {1'b0, a} - {1'b0, b};
    r.wrap = t[32];
    if (m == 0)
      r.diff = t[31:0] & mask[31:0];
    else if (t[32])
      r.diff = 32'(t + {1'b0, m});
    else
      r.diff = t[31:0];
    return r;
  endfunction

endpackage

// File: rtl/accu_wrap_sub.sv
// Combinational W-bit subtractor a-b with native 2^W wrap (M=0) or modulo-M wrap (M>0).
// wrap is set whenever a<b, i.e. whenever the wrap correction was needed.
module accu_wrap_sub #(
  parameter int W = 16,
  parameter int M = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         wrap
);

  localparam logic [W:0] M_EXT = (W+1)'(M);

  logic [W:0] t;
  logic [W:0] t_fix;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    t     = {1'b0, a} - {1'b0, b};
    t_fix = t + M_EXT;
    wrap  = t[W];
    // For M=2^W the low W bits of t already equal t+M, so M_EXT truncation is harmless.
    if (M > 0 && t[W])
      diff = t_fix[W-1:0];
    else
      diff = t[W-1:0];
  end

endmodule

// File: rtl/accu_diff.sv
// Differencer recovering per-sample increments from an accumulated stream (2^W or modulo-M wrap).
// Optional macro ACCU_DIFF_WRAP_CNT_EN adds a saturating 16-bit wrap_cnt output.
module accu_diff
  import accu_pkg::*;
#(
  parameter int W               = 16,
  parameter int M               = 0,
  parameter int FIRST_FROM_ZERO = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] acc_in,
  output logic [W-1:0] diff_out,
  output logic         out_valid,
`ifdef ACCU_DIFF_WRAP_CNT_EN
  output logic         range_err,
  output logic [15:0]  wrap_cnt
`else
  output logic         range_err
`endif
);

  if (M > 0 && 64'(M) > (64'd1 << W)) begin : g_bad_modulus
    $error("accu_diff: modulus M=%0d exceeds 2^W for W=%0d", M, W);
  end

  localparam bit         MODULAR = (M > 0);
  localparam logic [W:0] M_EXT   = (W+1)'(M);

  accu_diff_state_t state, state_d;
  logic [W-1:0]     prev, prev_d, diff_d;
  logic             valid_d, err_d;
  logic [W-1:0]     sub_diff;
  logic             sub_wrap;
  logic             legal, take;

  assign legal = !MODULAR || ({1'b0, acc_in} < M_EXT);
  assign take  = en && legal;

  accu_wrap_sub #(.W(W), .M(M)) u_sub (
    .a    (acc_in),
    .b    (prev),
    .diff (sub_diff),
    .wrap (sub_wrap)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (clr)       state_d = IDLE;
    else if (take) state_d = RUN;
  end

  // Next-value logic for the registered outputs; clr wins over en and discards the sample.
  always_comb begin
    prev_d  = prev;
    diff_d  = diff_out;
    valid_d = 1'b0;
    err_d   = range_err;
    if (clr) begin
      prev_d = '0;
    end else if (en) begin
      if (!legal) begin
        err_d = 1'b1;
      end else begin
        prev_d = acc_in;
        if (state == RUN) begin
          diff_d  = sub_diff;
          valid_d = 1'b1;
        end else if (FIRST_FROM_ZERO != 0) begin
          diff_d  = acc_in;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '0;
      diff_out  <= '0;
      out_valid <= 1'b0;
      range_err <= 1'b0;
    end else begin
      prev      <= prev_d;
      diff_out  <= diff_d;
      out_valid <= valid_d;
      range_err <= err_d;
    end
  end

`ifdef ACCU_DIFF_WRAP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || clr)
      wrap_cnt <= '0;
    else if (take && state == RUN && sub_wrap && wrap_cnt != 16'hFFFF)
      wrap_cnt <= wrap_cnt + 16'd1;
  end
`else
  logic wrap_unused;
  assign wrap_unused = sub_wrap;
`endif

endmodule

// File: tb/tb_accu_diff.sv
// Self-checking bench for accu_diff: three configurations against a behavioural model,
// directed scenarios followed by randomized en/clr/rst/acc_in stimulus.
module tb_accu_diff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, en;
  logic [15:0] a_p2;
  logic [5:0]  a_mod;
  logic [7:0]  a_nz;
  logic [15:0] d_p2;
  logic [5:0]  d_mod;
  logic [7:0]  d_nz;
  logic        v_p2, v_mod, v_nz;
  logic        e_p2, e_mod, e_nz;
`ifdef ACCU_DIFF_WRAP_CNT_EN
  logic [15:0] wc_p2, wc_mod, wc_nz;
`endif

  accu_diff #(.W(16), .M(0), .FIRST_FROM_ZERO(1)) u_p2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .acc_in(a_p2),
    .diff_out(d_p2), .out_valid(v_p2), .range_err(e_p2)
`ifdef ACCU_DIFF_WRAP_CNT_EN
    , .wrap_cnt(wc_p2)
`endif
  );

  accu_diff #(.W(6), .M(50), .FIRST_FROM_ZERO(1)) u_mod (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .acc_in(a_mod),
    .diff_out(d_mod), .out_valid(v_mod), .range_err(e_mod)
`ifdef ACCU_DIFF_WRAP_CNT_EN
    , .wrap_cnt(wc_mod)
`endif
  );

  accu_diff #(.W(8), .M(0), .FIRST_FROM_ZERO(0)) u_nz (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .acc_in(a_nz),
    .diff_out(d_nz), .out_valid(v_nz), .range_err(e_nz)
`ifdef ACCU_DIFF_WRAP_CNT_EN
    , .wrap_cnt(wc_nz)
`endif
  );

  // Reference model: one history slot per configuration.
  int     mw[3] = '{16, 6, 8};
  int     mm[3] = '{0, 50, 0};
  int     mf[3] = '{1, 1, 0};
  bit     m_have[3];
  longint m_prev[3], m_diff[3], m_wc[3];
  bit     m_valid[3], m_err[3];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_step(input int i, input longint a);
    longint modv;
    modv = (mm[i] != 0) ? longint'(mm[i]) : (longint'(1) << mw[i]);
    if (rst) begin
      m_have[i] = 0; m_prev[i] = 0; m_diff[i] = 0;
      m_valid[i] = 0; m_err[i] = 0; m_wc[i] = 0;
    end else if (clr) begin
      m_have[i] = 0; m_prev[i] = 0; m_valid[i] = 0; m_wc[i] = 0;
    end else if (en) begin
      if (mm[i] != 0 && a >= mm[i]) begin
        m_err[i] = 1; m_valid[i] = 0;
      end else if (!m_have[i]) begin
        m_have[i] = 1;
        m_prev[i] = a;
        if (mf[i] != 0) begin m_diff[i] = a; m_valid[i] = 1; end
        else m_valid[i] = 0;
      end else begin
        m_diff[i]  = (((a - m_prev[i]) % modv) + modv) % modv;
        if (a < m_prev[i] && m_wc[i] < 65535) m_wc[i]++;
        m_prev[i]  = a;
        m_valid[i] = 1;
      end
    end else begin
      m_valid[i] = 0;
    end
  endfunction

  task automatic compare_all();
    check("p2.diff", 64'(d_p2), m_diff[0]);
    check("p2.valid", 64'(v_p2), 64'(m_valid[0]));
    check("p2.err", 64'(e_p2), 64'(m_err[0]));
    check("mod.diff", 64'(d_mod), m_diff[1]);
    check("mod.valid", 64'(v_mod), 64'(m_valid[1]));
    check("mod.err", 64'(e_mod), 64'(m_err[1]));
    check("nz.diff", 64'(d_nz), m_diff[2]);
    check("nz.valid", 64'(v_nz), 64'(m_valid[2]));
    check("nz.err", 64'(e_nz), 64'(m_err[2]));
`ifdef ACCU_DIFF_WRAP_CNT_EN
    check("p2.wrap_cnt", 64'(wc_p2), m_wc[0]);
    check("mod.wrap_cnt", 64'(wc_mod), m_wc[1]);
    check("nz.wrap_cnt", 64'(wc_nz), m_wc[2]);
`endif
  endtask

  // Drive inputs while clk is low, advance one edge, update the model, compare on the falling edge.
  task automatic cycle(input longint v0, input longint v1, input longint v2);
    a_p2  = 16'(v0);
    a_mod = 6'(v1);
    a_nz  = 8'(v2);
    @(posedge clk);
    model_step(0, longint'(a_p2));
    model_step(1, longint'(a_mod));
    model_step(2, longint'(a_nz));
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0;
    cycle(0, 0, 0);
    check("rst.p2.diff", 64'(d_p2), 0);
    check("rst.p2.valid", 64'(v_p2), 0);
    check("rst.mod.err", 64'(e_mod), 0);

    rst = 1'b0; en = 1'b1;
    cycle(0, 45, 7);
    check("seq0.p2", 64'(d_p2), 0);
    check("seq0.p2.valid", 64'(v_p2), 1);
    check("seq0.mod", 64'(d_mod), 45);
    check("prime.nz.valid", 64'(v_nz), 0);
    cycle(1, 48, 9);
    check("seq1.p2", 64'(d_p2), 1);
    check("seq1.mod.wrap", 64'(d_mod), 3);
    check("nz.first", 64'(d_nz), 2);
    check("nz.first.valid", 64'(v_nz), 1);

    en = 1'b0;
    repeat (3) begin
      cycle(0, 0, 0);
      check("idle.nz.valid", 64'(v_nz), 0);
      check("idle.nz.hold", 64'(d_nz), 2);
    end

    en = 1'b1;
    cycle(3, 2, 11);
    check("seq2.p2", 64'(d_p2), 2);
    check("seq2.mod.wrap", 64'(d_mod), 4);
    cycle(6, 2, 12);
    check("seq3.p2", 64'(d_p2), 3);
    check("seq3.mod.zero", 64'(d_mod), 0);
    cycle(10, 10, 13);
    check("seq4.p2", 64'(d_p2), 4);
    cycle(16'hFFFE, 55, 14);
    check("illegal.mod.err", 64'(e_mod), 1);
    check("illegal.mod.valid", 64'(v_mod), 0);
    cycle(16'h0003, 12, 15);
    check("wrap.p2", 64'(d_p2), 5);
    check("after_illegal.mod", 64'(d_mod), 2);
    check("sticky.mod.err", 64'(e_mod), 1);
`ifdef ACCU_DIFF_WRAP_CNT_EN
    check("wrap.p2.cnt", 64'(wc_p2), 1);
`endif

    cycle(20, 20, 20);
    clr = 1'b1;
    cycle(25, 25, 25);
    check("clr.p2.valid", 64'(v_p2), 0);
    check("clr.mod.valid", 64'(v_mod), 0);
    clr = 1'b0;
    cycle(4, 4, 4);
    check("clr.p2.restart", 64'(d_p2), 4);
    check("clr.mod.restart", 64'(d_mod), 4);
    check("clr.keeps.err", 64'(e_mod), 1);
    check("clr.nz.prime", 64'(v_nz), 0);

    rst = 1'b1;
    cycle(9, 9, 9);
    check("midrst.p2.diff", 64'(d_p2), 0);
    check("midrst.mod.diff", 64'(d_mod), 0);
    check("midrst.mod.err", 64'(e_mod), 0);
    check("midrst.nz.valid", 64'(v_nz), 0);
    rst = 1'b0;

    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      clr = ($urandom_range(0, 99) < 5);
      en  = ($urandom_range(0, 99) < 75);
      cycle(($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 15)) : longint'($urandom_range(0, 65535)),
            longint'($urandom_range(0, 57)),
            longint'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
